// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor.
// State encoding and the legal WIDTH range live here.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic bit width_legal(
    input int unsigned w
  );
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_fs_cell.sv
// One-bit combinational full subtractor: x - y - br.
// Produces the difference bit and the outgoing borrow.
module serial_fs_cell (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic br_next
);

  assign d       = x ^ y ^ br;
  assign br_next = (~x & y) | (~x & br) | (y & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one cell plus shift registers.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (!width_legal(WIDTH)) begin : g_bad_width
      $error("serial_subtractor: WIDTH out of range");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_br;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  serial_fs_cell u_cell (
    .x       (a_sr_q[0]),
    .y       (b_sr_q[0]),
    .br      (br_q),
    .d       (cell_d),
    .br_next (cell_br)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    br_d      = br_q;
    bout_d    = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d     = ovf_q;
`endif
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (in_valid) begin
          state_d = ST_SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
        end
      end
      (state_q == ST_SHIFT): begin
        diff_sr_d = diff_sr_q >> 1;
        diff_sr_d[WIDTH-1] = cell_d;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = cell_br;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          bout_d  = cell_br;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit the LSBs hold the operand MSBs.
          ovf_d = (a_sr_q[0] != b_sr_q[0]) &&
                  (cell_d != a_sr_q[0]);
`endif
        end
      end
      (state_q == ST_DONE): begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      br_q      <= 1'b0;
      bout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      br_q      <= br_d;
      bout_q    <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_sr_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized + directed bench for serial_subtractor at WIDTH 8, 4, 1.
// Checks against an arithmetic reference model every DONE cycle.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, bi8, bo8;
  logic [7:0] a8, b8, d8;
  logic       iv4, ir4, ov4, or4, bi4, bo4;
  logic [3:0] a4, b4, d4;
  logic       iv1, ir1, ov1, or1, bi1, bo1;
  logic [0:0] a1, b1, d1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4, ovf1;
`endif

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .bin(bi8),
    .out_valid(ov8), .out_ready(or8),
    .diff(d8), .bout(bo8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .bin(bi4),
    .out_valid(ov4), .out_ready(or4),
    .diff(d4), .bout(bo4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .bin(bi1),
    .out_valid(ov1), .out_ready(or1),
    .diff(d1), .bout(bo1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  typedef logic [33:0] exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q8[$], q4[$], q1[$];
  int t8[$], t4[$], t1[$];
  logic p8 = 1'b0, p4 = 1'b0, p1 = 1'b0;

  function automatic void chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  // {ovf, bout, diff} from plain integer arithmetic
  function automatic exp_t model(
    input int w,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic bin
  );
    longint m, ua, ub, r, sa, sb, sr;
    logic bo, ov;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    r  = ua - ub - longint'(bin);
    bo = (ua < ub + longint'(bin));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sa - sb - longint'(bin);
    ov = (sr < -(m / 2)) || (sr >= m / 2);
    return {ov, bo, 32'(r & (m - 1))};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q8.delete(); t8.delete();
      q4.delete(); t4.delete();
      q1.delete(); t1.delete();
    end else begin
      if (ov8 && or8 && q8.size() > 0) begin
        q8.delete(0); t8.delete(0);
      end
      if (iv8 && ir8) begin
        q8.push_back(model(8, 32'(a8), 32'(b8), bi8));
        t8.push_back(cyc);
      end
      if (ov4 && or4 && q4.size() > 0) begin
        q4.delete(0); t4.delete(0);
      end
      if (iv4 && ir4) begin
        q4.push_back(model(4, 32'(a4), 32'(b4), bi4));
        t4.push_back(cyc);
      end
      if (ov1 && or1 && q1.size() > 0) begin
        q1.delete(0); t1.delete(0);
      end
      if (iv1 && ir1) begin
        q1.push_back(model(1, 32'(a1), 32'(b1), bi1));
        t1.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_spurious out_valid t=%0t", $time);
      end else begin
        chk("w8_diff", 64'(d8), 64'(q8[0][7:0]));
        chk("w8_bout", 64'(bo8), 64'(q8[0][32]));
`ifdef SERIAL_SUB_OVF_EN
        chk("w8_ovf", 64'(ovf8), 64'(q8[0][33]));
`endif
        chk("w8_inrdy", 64'(ir8), 64'(0));
        if (!p8) chk("w8_lat", 64'(cyc - t8[0]), 64'(8));
      end
    end
    if (rst_n && ov4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL w4_spurious out_valid t=%0t", $time);
      end else begin
        chk("w4_diff", 64'(d4), 64'(q4[0][3:0]));
        chk("w4_bout", 64'(bo4), 64'(q4[0][32]));
`ifdef SERIAL_SUB_OVF_EN
        chk("w4_ovf", 64'(ovf4), 64'(q4[0][33]));
`endif
        if (!p4) chk("w4_lat", 64'(cyc - t4[0]), 64'(4));
      end
    end
    if (rst_n && ov1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL w1_spurious out_valid t=%0t", $time);
      end else begin
        chk("w1_diff", 64'(d1), 64'(q1[0][0]));
        chk("w1_bout", 64'(bo1), 64'(q1[0][32]));
`ifdef SERIAL_SUB_OVF_EN
        chk("w1_ovf", 64'(ovf1), 64'(q1[0][33]));
`endif
        if (!p1) chk("w1_lat", 64'(cyc - t1[0]), 64'(1));
      end
    end
    p8 = ov8;
    p4 = ov4;
    p1 = ov1;
  end

  task automatic drive(
    input int w,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic bin,
    input logic iv
  );
    case (w)
      8: begin a8 = a[7:0]; b8 = b[7:0]; bi8 = bin; iv8 = iv; end
      4: begin a4 = a[3:0]; b4 = b[3:0]; bi4 = bin; iv4 = iv; end
      default: begin
        a1 = a[0:0]; b1 = b[0:0]; bi1 = bin; iv1 = iv;
      end
    endcase
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      8: or8 = v;
      4: or4 = v;
      default: or1 = v;
    endcase
  endtask

  function automatic logic ir_of(input int w);
    return (w == 8) ? ir8 : (w == 4) ? ir4 : ir1;
  endfunction

  function automatic logic ov_of(input int w);
    return (w == 8) ? ov8 : (w == 4) ? ov4 : ov1;
  endfunction

  function automatic logic [32:0] res_of(input int w);
    if (w == 8) return {bo8, 24'd0, d8};
    if (w == 4) return {bo4, 28'd0, d4};
    return {bo1, 31'd0, d1};
  endfunction

  // Called and returns at posedge+1; res = {bout, diff}
  task automatic do_op(
    input int w,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic bin,
    input int stall,
    input bit noise,
    output logic [32:0] res,
    output int lat
  );
    int n;
    logic [32:0] hold;
    res = '0;
    lat = -1;
    drive(w, a, b, bin, 1'b1);
    set_or(w, stall == 0);
    n = 0;
    while (!ir_of(w) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ir_of(w)) begin
      checks++; errors++;
      $display("FAIL accept_timeout w=%0d in_ready=0", w);
      drive(w, a, b, bin, 1'b0);
      return;
    end
    @(posedge clk); #1;
    if (noise) drive(w, $urandom, $urandom, 1'($urandom), 1'b1);
    else       drive(w, a, b, bin, 1'b0);
    n = 0;
    while (!ov_of(w) && n < w + 10) begin
      @(posedge clk); #1; n++;
      if (noise) drive(w, $urandom, $urandom, 1'($urandom), 1'b1);
    end
    if (!ov_of(w)) begin
      checks++; errors++;
      $display("FAIL out_timeout w=%0d out_valid=0", w);
      drive(w, a, b, bin, 1'b0);
      set_or(w, 1'b1);
      return;
    end
    lat = n;
    res = res_of(w);
    hold = res;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_ov", 64'(ov_of(w)), 64'(1));
      chk("stall_ir", 64'(ir_of(w)), 64'(0));
      chk("stall_hold", 64'(res_of(w)), 64'(hold));
    end
    set_or(w, 1'b1);
    @(posedge clk); #1;
    chk("post_ov", 64'(ov_of(w)), 64'(0));
    chk("post_ir", 64'(ir_of(w)), 64'(1));
    drive(w, a, b, bin, 1'b0);
  endtask

  logic [32:0] res;
  int lat;

  initial begin
    drive(8, 0, 0, 0, 0);
    drive(4, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    or8 = 1'b1; or4 = 1'b1; or1 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ir8", 64'(ir8), 64'(1));
    chk("rst_ov8", 64'(ov8), 64'(0));
    chk("rst_d8", 64'(d8), 64'(0));
    chk("rst_bo8", 64'(bo8), 64'(0));
    chk("rst_ir4", 64'(ir4), 64'(1));
    chk("rst_ir1", 64'(ir1), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("pin_5a3c", 64'(model(8, 'h5A, 'h3C, 0)), 64'h0_0000_001E);
    chk("pin_0001", 64'(model(8, 'h00, 'h01, 0)), 64'h1_0000_00FF);
    chk("pin_00b1", 64'(model(8, 'h00, 'h00, 1)), 64'h1_0000_00FF);
    chk("pin_8001", 64'(model(8, 'h80, 'h01, 0)), 64'h2_0000_007F);
    chk("pin_7fff", 64'(model(8, 'h7F, 'hFF, 0)), 64'h3_0000_0080);
    chk("pin_w4", 64'(model(4, 'h0, 'hF, 1)), 64'h1_0000_0000);

    do_op(8, 'h5A, 'h3C, 0, 0, 0, res, lat);
    chk("op_5a3c", 64'(res), {31'd0, 1'b0, 32'h1E});
    chk("op_5a3c_lat", 64'(lat), 64'(8));
    do_op(8, 'h00, 'h01, 0, 0, 0, res, lat);
    chk("op_0001", 64'(res), {31'd0, 1'b1, 32'hFF});
    do_op(8, 'h00, 'h00, 1, 0, 0, res, lat);
    chk("op_00b1", 64'(res), {31'd0, 1'b1, 32'hFF});
    do_op(8, 'h80, 'h01, 0, 0, 0, res, lat);
    chk("op_8001", 64'(res), {31'd0, 1'b0, 32'h7F});
`ifdef SERIAL_SUB_OVF_EN
    chk("op_8001_ovf", 64'(ovf8), 64'(1));
`endif
    do_op(8, 'h7F, 'hFF, 0, 0, 0, res, lat);
    chk("op_7fff", 64'(res), {31'd0, 1'b1, 32'h80});
`ifdef SERIAL_SUB_OVF_EN
    chk("op_7fff_ovf", 64'(ovf8), 64'(1));
`endif

    // Backpressure with in_valid and operand noise while busy
    do_op(8, 'h33, 'h44, 1, 5, 1, res, lat);
    chk("op_bp", 64'(res), {31'd0, 1'b1, 32'hEE});

    // Async reset after the third shift edge
    drive(8, 'hA5, 'h0F, 0, 1'b1);
    @(posedge clk); #1;
    drive(8, 'hA5, 'h0F, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ov", 64'(ov8), 64'(0));
    chk("midrst_ir", 64'(ir8), 64'(1));
    chk("midrst_d", 64'(d8), 64'(0));
    chk("midrst_bo", 64'(bo8), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(8, 'h10, 'h01, 0, 0, 0, res, lat);
    chk("op_1001", 64'(res), {31'd0, 1'b0, 32'h0F});

    for (int i = 0; i < 40; i++) begin
      do_op(8, $urandom, $urandom, 1'($urandom),
            int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), res, lat);
    end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          do_op(4, 32'(x), 32'(y), 1'(c), 0, 0, res, lat);
          chk("w4_op_lat", 64'(lat), 64'(4));
        end

    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++) begin
          do_op(1, 32'(x), 32'(y), 1'(c),
                int'($urandom_range(0, 2)), 0, res, lat);
          chk("w1_op_lat", 64'(lat), 64'(1));
        end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
